data_sram_resp: RTL

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/data_sram_resp.sv
// data_sram_resp: CPU data port -> sync SRAM, 2-entry in-order queue; response at T+2+LATENCY, ready = (count < 2).
// DRESP_WSTRB_SIZE_EN: store byte enables follow data_size/addr; undefined, every store writes all four lanes.
module data_sram_resp #(
  parameter int LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_addr_valid,
  output logic        data_addr_ready,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_bvalid,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      r_state;
  logic        r_q_wr    [2];
  logic [1:0]  r_q_size  [2];
  logic [31:0] r_q_addr  [2];
  logic [31:0] r_q_wdata [2];
  logic        r_wptr, r_rptr;
  logic [1:0]  r_count;
  logic [3:0]  r_cnt;
  logic        r_cur_wr;
  logic        r_cap;
  logic [31:0] r_rdata;
  logic        r_ram_en, r_rvalid, r_bvalid;
  logic [3:0]  r_ram_we;
  logic [31:0] r_ram_addr, r_ram_wdata;

  logic        w_q_empty, w_push, w_take, w_pop, w_push_q;
  logic        w_sel_wr;
  logic [1:0]  w_sel_size;
  logic [31:0] w_sel_addr, w_sel_wdata;
  logic [3:0]  w_we;

  assign data_addr_ready = (r_count < 2'd2);
  assign w_q_empty = (r_count == 2'd0);
  assign w_push    = data_addr_valid && data_addr_ready;
  assign w_take    = ((r_state == S_IDLE) || (r_state == S_RESP)) && (!w_q_empty || w_push);
  assign w_pop     = w_take && !w_q_empty;
  // An empty queue lets the incoming request go straight to the engine, giving ram_en at T+1.
  assign w_push_q  = w_push && !(w_take && w_q_empty);

  assign w_sel_wr    = w_q_empty ? data_wr    : r_q_wr[r_rptr];
  assign w_sel_size  = w_q_empty ? data_size  : r_q_size[r_rptr];
  assign w_sel_addr  = w_q_empty ? data_addr  : r_q_addr[r_rptr];
  assign w_sel_wdata = w_q_empty ? data_wdata : r_q_wdata[r_rptr];

  always_comb begin
    w_we = 4'b0000;
    if (w_sel_wr) begin
`ifdef DRESP_WSTRB_SIZE_EN
      case (w_sel_size)
        2'd0:    w_we = 4'b0001 << w_sel_addr[1:0];
        2'd1:    w_we = 4'b0011 << {w_sel_addr[1], 1'b0};
        default: w_we = 4'b1111;
      endcase
`else
      w_we = 4'b1111;
`endif
    end
  end

`ifndef DRESP_WSTRB_SIZE_EN
  logic w_unused;
  assign w_unused = ^{w_sel_size, w_sel_addr[1:0]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      if (w_push_q) r_wptr <= ~r_wptr;
      if (w_pop)    r_rptr <= ~r_rptr;
      case ({w_push_q, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_q) begin
      r_q_wr[r_wptr]    <= data_wr;
      r_q_size[r_wptr]  <= data_size;
      r_q_addr[r_wptr]  <= data_addr;
      r_q_wdata[r_wptr] <= data_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_cur_wr    <= 1'b0;
      r_cap       <= 1'b0;
      r_rdata     <= 32'd0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 4'd0;
      r_ram_addr  <= 32'd0;
      r_ram_wdata <= 32'd0;
      r_rvalid    <= 1'b0;
      r_bvalid    <= 1'b0;
    end else begin
      r_ram_en <= 1'b0;
      r_ram_we <= 4'd0;
      r_rvalid <= 1'b0;
      r_bvalid <= 1'b0;
      r_cap    <= (r_state == S_ISSUE);
      if (r_cap) r_rdata <= ram_rdata;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_take) begin
            r_state     <= S_ISSUE;
            r_ram_en    <= 1'b1;
            r_ram_we    <= w_we;
            r_ram_addr  <= {w_sel_addr[31:2], 2'b00};
            r_ram_wdata <= w_sel_wdata;
            r_cur_wr    <= w_sel_wr;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (LATENCY > 0) begin
            r_state <= S_WAIT;
            r_cnt   <= LAT_M1;
          end else begin
            r_state  <= S_RESP;
            r_rvalid <= !r_cur_wr;
            r_bvalid <= r_cur_wr;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state  <= S_RESP;
            r_rvalid <= !r_cur_wr;
            r_bvalid <= r_cur_wr;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_en      = r_ram_en;
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign data_rvalid = r_rvalid;
  assign data_bvalid = r_bvalid;
  // With LATENCY=0 the response cycle is also the capture cycle, so RAM data is forwarded.
  assign data_rdata  = r_cap ? ram_rdata : r_rdata;
endmodule
